// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM states, pulse-width windows in
// 10 us ticks, and a window-compare helper.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_RPT_MARK
  } ir_state_t;

  localparam int          TICK_US   = 10;
  localparam int          WIDTH_W   = 11;
  localparam logic [10:0] WIDTH_MAX = 11'd2047;

  localparam logic [10:0] LEAD_MARK_MIN  = 11'd800;
  localparam logic [10:0] LEAD_MARK_MAX  = 11'd1000;
  localparam logic [10:0] DATA_SPACE_MIN = 11'd400;
  localparam logic [10:0] DATA_SPACE_MAX = 11'd500;
  localparam logic [10:0] RPT_SPACE_MIN  = 11'd180;
  localparam logic [10:0] RPT_SPACE_MAX  = 11'd270;
  localparam logic [10:0] BIT_MARK_MIN   = 11'd40;
  localparam logic [10:0] BIT_MARK_MAX   = 11'd70;
  localparam logic [10:0] ZERO_SPACE_MIN = 11'd40;
  localparam logic [10:0] ZERO_SPACE_MAX = 11'd70;
  localparam logic [10:0] ONE_SPACE_MIN  = 11'd140;
  localparam logic [10:0] ONE_SPACE_MAX  = 11'd190;
  localparam logic [10:0] TIMEOUT        = 11'd1100;

  function automatic logic in_window(input logic [10:0] w, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_rx_conditioner.sv
// Two-flop synchroniser plus stability filter for the raw IR pin; emits the
// filtered mark level and a one-cycle strobe whenever that level changes.
module ir_rx_conditioner #(
  parameter int DEGLITCH      = 8,
  parameter int RX_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic mark,
  output logic mark_edge
);

  localparam int             CW         = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEGLITCH - 1);
  localparam logic           IDLE_LEVEL = (RX_ACTIVE_LOW != 0);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          mark_reg;
  logic          edge_reg;
  logic          raw_mark;

  // Line idles at the non-mark level, so the synchroniser resets there too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= {IDLE_LEVEL, IDLE_LEVEL};
    else        sync_reg <= {sync_reg[0], rx};
  end

  assign raw_mark = sync_reg[1] ^ IDLE_LEVEL;

  // A new level is accepted only after DEGLITCH consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      mark_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      edge_reg <= 1'b0;
      if (raw_mark == mark_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg  <= '0;
        mark_reg <= raw_mark;
        edge_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign mark      = mark_reg;
  assign mark_edge = edge_reg;

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: measures mark/space widths in 10 us ticks and walks
// the leader/data/repeat sequence, publishing validated 32-bit codes.
module ir_nec_receiver
  import ir_pkg::*;
#(
  parameter int CLK_HZ        = 74_250_000,
  parameter int DEGLITCH      = 8,
  parameter int RX_ACTIVE_LOW = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ir_rx_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        busy_out
);

  localparam int            TICK_DIV  = CLK_HZ / (1_000_000 / TICK_US);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic               mark, mark_edge, mark_rise, mark_fall;
  logic [PW-1:0]      presc_reg;
  logic               tick;
  logic [WIDTH_W-1:0] width_reg;
  ir_state_t          state_reg, state_next;
  logic [31:0]        shreg_reg, shreg_shifted;
  logic [4:0]         bitcnt_reg;
  logic               have_code_reg;
  logic               shift_en, bit_val, clr_bitcnt, frame_done, rpt_hit;

  ir_rx_conditioner #(
    .DEGLITCH      (DEGLITCH),
    .RX_ACTIVE_LOW (RX_ACTIVE_LOW)
  ) u_cond (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .rx        (ir_rx_in),
    .mark      (mark),
    .mark_edge (mark_edge)
  );

  assign mark_rise = mark_edge & mark;
  assign mark_fall = mark_edge & ~mark;
  assign tick      = (presc_reg == TICK_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + 1'b1;
  end

  // Width of the current mark or space; restarts at every accepted edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                          width_reg <= '0;
    else if (mark_edge)                     width_reg <= '0;
    else if (tick && width_reg != WIDTH_MAX) width_reg <= width_reg + 11'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    bit_val    = 1'b0;
    clr_bitcnt = 1'b0;
    frame_done = 1'b0;
    rpt_hit    = 1'b0;
    case (state_reg)
      ST_IDLE:       if (mark_rise) state_next = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (mark_fall)
                       state_next = in_window(width_reg, LEAD_MARK_MIN, LEAD_MARK_MAX)
                                    ? ST_LEAD_SPACE : ST_IDLE;
      ST_LEAD_SPACE: if (mark_rise) begin
                       if (in_window(width_reg, DATA_SPACE_MIN, DATA_SPACE_MAX)) begin
                         state_next = ST_BIT_MARK;
                         clr_bitcnt = 1'b1;
                       end else if (in_window(width_reg, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                         state_next = ST_RPT_MARK;
                       end else begin
                         state_next = ST_IDLE;
                       end
                     end
      ST_BIT_MARK:   if (mark_fall)
                       state_next = in_window(width_reg, BIT_MARK_MIN, BIT_MARK_MAX)
                                    ? ST_BIT_SPACE : ST_IDLE;
      ST_BIT_SPACE:  if (mark_rise) begin
                       if (in_window(width_reg, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
                         shift_en = 1'b1;
                       end else if (in_window(width_reg, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                         shift_en = 1'b1;
                         bit_val  = 1'b1;
                       end
                       if (!shift_en)               state_next = ST_IDLE;
                       else if (bitcnt_reg == 5'd31) begin
                         state_next = ST_STOP_MARK;
                         frame_done = 1'b1;
                       end else                     state_next = ST_BIT_MARK;
                     end
      ST_STOP_MARK:  if (mark_fall) state_next = ST_IDLE;
      ST_RPT_MARK:   if (mark_fall) begin
                       rpt_hit    = in_window(width_reg, BIT_MARK_MIN, BIT_MARK_MAX) & have_code_reg;
                       state_next = ST_IDLE;
                     end
      default:       state_next = ST_IDLE;
    endcase
    // A stalled line aborts silently from any active state.
    if (state_reg != ST_IDLE && width_reg > TIMEOUT) begin
      state_next = ST_IDLE;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      rpt_hit    = 1'b0;
    end
  end

  assign shreg_shifted = {shreg_reg[30:0], bit_val};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg_reg     <= '0;
      bitcnt_reg    <= '0;
      have_code_reg <= 1'b0;
      code_out      <= '0;
      valid_out     <= 1'b0;
      repeat_out    <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      repeat_out <= 1'b0;
      if (clr_bitcnt) begin
        bitcnt_reg <= '0;
        shreg_reg  <= '0;
      end
      if (shift_en) begin
        shreg_reg  <= shreg_shifted;
        bitcnt_reg <= bitcnt_reg + 5'd1;
      end
      if (frame_done && (shreg_shifted[15:8] == ~shreg_shifted[7:0])) begin
        code_out      <= shreg_shifted;
        valid_out     <= 1'b1;
        have_code_reg <= 1'b1;
      end
      if (rpt_hit) repeat_out <= 1'b1;
    end
  end

  assign busy_out = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Randomised-timing bench for ir_nec_receiver; a frame-level model tracks the
// expected code, pulse counts and repeat eligibility.
module tb_ir_nec_receiver;

  localparam int CLK_HZ = 100_000;
  localparam int DEG    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  logic [31:0] code;
  logic        valid, rpt, busy;

  int n_cmp = 0, n_fail = 0;
  int valid_cnt = 0, rpt_cnt = 0, pulse_err = 0;
  logic valid_d = 1'b0, rpt_d = 1'b0;

  logic [31:0] model_code = '0;
  bit          model_have = 1'b0;

  always #5 clk = ~clk;

  ir_nec_receiver #(
    .CLK_HZ        (CLK_HZ),
    .DEGLITCH      (DEG),
    .RX_ACTIVE_LOW (1)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .ir_rx_in   (ir),
    .code_out   (code),
    .valid_out  (valid),
    .repeat_out (rpt),
    .busy_out   (busy)
  );

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (rpt) rpt_cnt++;
    if ((valid && valid_d) || (rpt && rpt_d)) pulse_err++;
    valid_d = valid;
    rpt_d   = rpt;
  end

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  // Frame-level model: a frame is accepted iff the command byte carries its complement.
  function automatic int model_frame(input logic [31:0] c);
    if (c[15:8] == ~c[7:0]) begin
      model_code = c;
      model_have = 1'b1;
      return 1;
    end
    return 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic mark_for(input int n);
    ir = 1'b0;
    cyc(n);
  endtask

  task automatic space_for(input int n);
    ir = 1'b1;
    cyc(n);
  endtask

  // One tick per cycle at this CLK_HZ, so widths below are in ticks.
  task automatic send_frame(input logic [31:0] c, input int nbits, input bit full,
                            input int glitch_bit);
    int w, k;
    mark_for(rnd(860, 940));
    space_for(rnd(420, 480));
    for (int i = 0; i < nbits; i++) begin
      mark_for(rnd(48, 62));
      if (!full && i == nbits - 1) begin
        ir = 1'b1;
        return;
      end
      w = c[31-i] ? rnd(155, 180) : rnd(48, 62);
      if (i == glitch_bit) begin
        k = rnd(1, 3);
        space_for(w / 2);
        mark_for(k);
        space_for(w - w / 2 - k);
      end else begin
        space_for(w);
      end
    end
    if (full) begin
      mark_for(56);
      ir = 1'b1;
    end
  endtask

  task automatic send_repeat();
    mark_for(rnd(860, 940));
    space_for(rnd(200, 250));
    mark_for(rnd(48, 62));
    ir = 1'b1;
  endtask

  function automatic logic [31:0] rand_code(input bit corrupt);
    logic [7:0] a, m;
    logic [31:0] c;
    a = 8'($urandom);
    m = 8'($urandom);
    c = {a, ~a, m, ~m};
    if (corrupt) c[7:0] = c[7:0] ^ 8'(rnd(1, 255));
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    @(negedge clk);
    n_cmp += 4;
    if (code !== 32'h0) begin n_fail++; $display("FAIL reset_code: got %h want %h", code, 32'h0); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (rpt !== 1'b0)   begin n_fail++; $display("FAIL reset_repeat: got %b want 0", rpt); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    $display("reset: code=%h busy=%b", code, busy);
  endtask

  task automatic test_repeat(input string name);
    int r0, v0, exp_r;
    r0 = rpt_cnt;
    v0 = valid_cnt;
    exp_r = model_have ? 1 : 0;
    send_repeat();
    cyc(20);
    @(negedge clk);
    n_cmp += 4;
    if (rpt_cnt - r0 !== exp_r) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, rpt_cnt - r0, exp_r); end
    if (valid_cnt - v0 !== 0)   begin n_fail++; $display("FAIL %s_valid: got %0d want 0", name, valid_cnt - v0); end
    if (code !== model_code)    begin n_fail++; $display("FAIL %s_code: got %h want %h", name, code, model_code); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL %s_busy: got %b want 0", name, busy); end
    $display("%s: repeats=%0d code=%h", name, rpt_cnt - r0, code);
  endtask

  task automatic test_frame(input string name, input logic [31:0] c, input int glitch_bit);
    int v0, exp_v;
    v0 = valid_cnt;
    send_frame(c, 32, 1'b1, glitch_bit);
    cyc(20);
    exp_v = model_frame(c);
    @(negedge clk);
    n_cmp += 3;
    if (valid_cnt - v0 !== exp_v) begin n_fail++; $display("FAIL %s_valid: got %0d want %0d", name, valid_cnt - v0, exp_v); end
    if (code !== model_code)      begin n_fail++; $display("FAIL %s_code: got %h want %h", name, code, model_code); end
    if (busy !== 1'b0)            begin n_fail++; $display("FAIL %s_busy: got %b want 0", name, busy); end
    $display("%s: sent=%h valid=%0d code=%h", name, c, valid_cnt - v0, code);
  endtask

  task automatic test_timeout();
    int v0;
    v0 = valid_cnt;
    send_frame(32'h20DF_5BA4, 20, 1'b0, -1);
    cyc(1050);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early_busy: got %b want 1", busy); end
    cyc(80);
    @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    if (valid_cnt - v0 !== 0)   begin n_fail++; $display("FAIL timeout_valid: got %0d want 0", valid_cnt - v0); end
    if (code !== model_code)    begin n_fail++; $display("FAIL timeout_code: got %h want %h", code, model_code); end
    $display("timeout: busy=%b code=%h", busy, code);
    test_frame("after_timeout", 32'h20DF_5AA5, -1);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 2; i++) test_frame("random", rand_code(bit'($urandom_range(1))), -1);
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 3; k++) begin
      mark_for(k);
      space_for(20);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_%0d: got busy %b want 0", k, busy); end
      $display("glitch idle %0d cycles: busy=%b", k, busy);
    end
    test_frame("glitch_frame", rand_code(1'b0), rnd(0, 31));
  endtask

  task automatic test_midframe_reset();
    send_frame(rand_code(1'b0), 10, 1'b0, -1);
    cyc(30);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_busy: got %b want 1", busy); end
    cyc(1);
    ir = 1'b0;
    cyc(10);
    #1;
    rst_n = 1'b0;
    #1;
    model_code = '0;
    model_have = 1'b0;
    n_cmp += 4;
    if (code !== 32'h0) begin n_fail++; $display("FAIL midreset_code: got %h want %h", code, 32'h0); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", valid); end
    if (rpt !== 1'b0)   begin n_fail++; $display("FAIL midreset_repeat: got %b want 0", rpt); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    $display("midframe reset: code=%h busy=%b", code, busy);
    cyc(3);
    ir = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    test_frame("after_reset", rand_code(1'b0), -1);
  endtask

  task automatic test_pulse_shape();
    n_cmp++;
    if (pulse_err !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d stretched pulses want 0", pulse_err); end
  endtask

  initial begin
    test_reset();
    test_repeat("repeat_no_code");
    test_frame("frame_5BA4", 32'h20DF_5BA4, -1);
    test_frame("bad_complement", 32'h20DF_5BA5, -1);
    test_repeat("repeat");
    test_timeout();
    test_random_frames();
    test_glitch();
    test_midframe_reset();
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
